// File: rtl/tetris_pkg.sv
// Shared constants and helpers for the Tetris game-logic blocks.
package tetris_pkg;

  localparam int LEVEL_W = 4;

  // Default speed profile, in milliseconds.
  localparam int unsigned DEF_BASE_MS = 1000;
  localparam int unsigned DEF_STEP_MS = 60;
  localparam int unsigned DEF_MIN_MS  = 100;
  localparam int unsigned DEF_FAST_MS = 50;

  // Milliseconds to clock cycles; the integer cycles-per-ms is taken first so
  // every period is an exact multiple of it.
  function automatic logic [63:0] ms_to_cycles(input int unsigned ms,
                                               input int unsigned clk_hz);
    return 64'(ms) * 64'(clk_hz / 1000);
  endfunction

  // Level-derived period in ms, clamped to min_ms without ever underflowing.
  function automatic int unsigned level_ms(input int unsigned lvl,
                                           input int unsigned base_ms,
                                           input int unsigned step_ms,
                                           input int unsigned min_ms);
    int unsigned d;
    d = lvl * step_ms;
    if (d >= base_ms || (base_ms - d) < min_ms) return min_ms;
    return base_ms - d;
  endfunction

endpackage

// File: rtl/drop_timer_if.sv
// Control/status bundle between the input logic, the drop timer and the
// piece-drop state machine.
interface drop_timer_if import tetris_pkg::*; #(
  parameter int TCNT_W = 16
) ();
  logic [LEVEL_W-1:0] level;
  logic               fast;
  logic               pause;
  logic               restart;
  logic               tick;
  logic               sq;
  logic [TCNT_W-1:0]  tick_cnt;

  // Controller side: drives speed/flow controls, consumes the timebase.
  modport master (output level, fast, pause, restart,
                  input  tick, sq, tick_cnt);
  // Timer side.
  modport slave  (input  level, fast, pause, restart,
                  output tick, sq, tick_cnt);
endinterface

// File: rtl/drop_period_lut.sv
// Combinational (level, fast) -> period-in-cycles map. The whole table is
// folded into constants at elaboration, so no multiplier is built.
module drop_period_lut import tetris_pkg::*; #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned LEVELS  = 16,
  parameter int unsigned BASE_MS = DEF_BASE_MS,
  parameter int unsigned STEP_MS = DEF_STEP_MS,
  parameter int unsigned MIN_MS  = DEF_MIN_MS,
  parameter int unsigned FAST_MS = DEF_FAST_MS,
  parameter int          CNT_W   = 30
) (
  input  logic [LEVEL_W-1:0] i_level,
  input  logic               i_fast,
  output logic [CNT_W-1:0]   o_period
);

  localparam int NTAB = 2 ** LEVEL_W;
  localparam logic [CNT_W-1:0] FAST_P = CNT_W'(ms_to_cycles(FAST_MS, CLK_HZ));

  // One entry per encodable level; codes past LEVELS-1 repeat the top entry,
  // which gives the level saturation for free.
  logic [CNT_W-1:0] w_tab [NTAB];

  for (genvar g = 0; g < NTAB; g++) begin : g_tab
    localparam int unsigned LV = (32'(g) < LEVELS) ? 32'(g) : LEVELS - 1;
    assign w_tab[g] = CNT_W'(ms_to_cycles(level_ms(LV, BASE_MS, STEP_MS, MIN_MS),
                                          CLK_HZ));
  end

  assign o_period = i_fast ? FAST_P : w_tab[i_level];

endmodule

// File: rtl/drop_timer.sv
// Gravity timebase: one-cycle tick per level/soft-drop period, with pause,
// resynchronising restart, a 50% blink output and a tick counter.
module drop_timer import tetris_pkg::*; #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned LEVELS  = 16,
  parameter int unsigned BASE_MS = DEF_BASE_MS,
  parameter int unsigned STEP_MS = DEF_STEP_MS,
  parameter int unsigned MIN_MS  = DEF_MIN_MS,
  parameter int unsigned FAST_MS = DEF_FAST_MS,
  parameter int          CNT_W   = 30,
  parameter int          TCNT_W  = 16
) (
  input  logic         clk100m,
  input  logic         rst_n,
  drop_timer_if.slave  bus
);

  // Level-0, non-fast period loaded by reset.
  localparam logic [CNT_W-1:0] P_RST =
    CNT_W'(ms_to_cycles(level_ms(0, BASE_MS, STEP_MS, MIN_MS), CLK_HZ));

  if ((64'(BASE_MS) * 64'(CLK_HZ) / 64'd1000) >= (64'd1 << CNT_W)) begin : g_cnt_w_chk
    $error("drop_timer: CNT_W too narrow for BASE_MS period");
  end
  if (MIN_MS < 1 || FAST_MS < 1) begin : g_ms_chk
    $error("drop_timer: MIN_MS and FAST_MS must be at least 1");
  end

  logic [CNT_W-1:0]  w_period;
  logic [CNT_W-1:0]  w_lim;
  logic [CNT_W-1:0]  r_period_q;
  logic [CNT_W-1:0]  r_count;
  logic              r_tick;
  logic              r_sq;
  logic [TCNT_W-1:0] r_tick_cnt;

  drop_period_lut #(
    .CLK_HZ (CLK_HZ),  .LEVELS (LEVELS),
    .BASE_MS(BASE_MS), .STEP_MS(STEP_MS),
    .MIN_MS (MIN_MS),  .FAST_MS(FAST_MS),
    .CNT_W  (CNT_W)
  ) u_lut (
    .i_level (bus.level),
    .i_fast  (bus.fast),
    .o_period(w_period)
  );

  // Register the period every cycle (restart/pause do not freeze it).
  always_ff @(posedge clk100m) begin
    if (!rst_n) r_period_q <= P_RST;
    else        r_period_q <= w_period;
  end

  // Greater-or-equal compare so a shortened period fires on the next edge
  // instead of waiting for the counter to wrap.
  assign w_lim = r_period_q - CNT_W'(1);

  // Period counter, tick pulse, blink toggle and tick count.
  always_ff @(posedge clk100m) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_sq       <= 1'b0;
      r_tick_cnt <= '0;
    end else if (bus.restart) begin
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_tick_cnt <= '0;
    end else if (bus.pause) begin
      r_tick     <= 1'b0;
    end else if (r_count >= w_lim) begin
      r_count    <= '0;
      r_tick     <= 1'b1;
      r_sq       <= ~r_sq;
      r_tick_cnt <= r_tick_cnt + TCNT_W'(1);
    end else begin
      r_count    <= r_count + CNT_W'(1);
      r_tick     <= 1'b0;
    end
  end

  assign bus.tick     = r_tick;
  assign bus.sq       = r_sq;
  assign bus.tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_drop_timer.sv
// Randomised + directed bench for drop_timer with a cycle-level reference
// model; expected ticks are queued and checked by an independent monitor.
module tb_drop_timer;

  localparam int CLK_HZ = 10_000, LEVELS = 8, BASE_MS = 4, STEP_MS = 1;
  localparam int MIN_MS = 1, FAST_MS = 1, TCNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  drop_timer_if #(.TCNT_W(TCNT_W)) bus ();

  drop_timer #(
    .CLK_HZ(CLK_HZ), .LEVELS(LEVELS), .BASE_MS(BASE_MS), .STEP_MS(STEP_MS),
    .MIN_MS(MIN_MS), .FAST_MS(FAST_MS), .CNT_W(30), .TCNT_W(TCNT_W)
  ) u_dut (
    .clk100m(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct { int cyc; bit sq; int tc; } exp_t;
  exp_t q[$];

  int n_vec = 0, n_err = 0;
  int mon_cyc = 0;

  // Reference model state (describes the outcome of each rising edge).
  int m_cyc = 0, m_el = 0, m_per = 0, m_tc = 0;
  bit m_sq = 0, m_tick = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, mon_cyc);
    end
  endtask

  // Spec period formula in cycles, plain arithmetic.
  function automatic int period_of(input int lvl, input bit fst);
    int l, ms;
    if (fst) return FAST_MS * (CLK_HZ / 1000);
    l  = (lvl > LEVELS - 1) ? LEVELS - 1 : lvl;
    ms = BASE_MS - l * STEP_MS;
    if (ms < MIN_MS) ms = MIN_MS;
    return ms * (CLK_HZ / 1000);
  endfunction

  // Predict the effect of the coming rising edge given the current inputs.
  task automatic step();
    m_cyc++;
    m_tick = 0;
    if (!rst_n) begin
      m_el = 0; m_sq = 0; m_tc = 0;
      m_per = period_of(0, 0);
    end else begin
      if (bus.restart) begin
        m_el = 0; m_tc = 0;
      end else if (!bus.pause) begin
        m_el++;                          // cycles elapsed in this period
        if (m_el >= m_per) begin
          m_el = 0; m_sq = !m_sq; m_tc = (m_tc + 1) % (1 << TCNT_W); m_tick = 1;
          q.push_back('{m_cyc, m_sq, m_tc});
        end
      end
      m_per = period_of(int'(bus.level), bus.fast); // seen from the next edge on
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic snap(input string nm);
    chk({nm, "_tick"}, int'(bus.tick), int'(m_tick));
    chk({nm, "_sq"}, int'(bus.sq), int'(m_sq));
    chk({nm, "_tick_cnt"}, int'(bus.tick_cnt), m_tc);
  endtask

  always @(posedge clk) mon_cyc <= mon_cyc + 1;

  // Monitor: flag overdue expectations, then match each DUT tick.
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc < mon_cyc) begin
      e = q.pop_front();
      chk("tick_missing", int'(bus.tick) + mon_cyc, e.cyc);
    end
    if (bus.tick === 1'b1) begin
      if (q.size() == 0) chk("tick_extra", int'(bus.tick), 0);
      else begin
        e = q.pop_front();
        chk("tick_cycle", mon_cyc, e.cyc);
        chk("tick_sq", int'(bus.sq), int'(e.sq));
        chk("tick_cnt", int'(bus.tick_cnt), e.tc);
      end
    end
  end

  task automatic pulse_restart();
    bus.restart = 1'b1; run(1); bus.restart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.level = '0; bus.fast = 1'b0; bus.pause = 1'b0; bus.restart = 1'b0;
    run(3);
    snap("reset");
    rst_n = 1'b1;

    // Level 0: 40-cycle period, three ticks.
    run(125);
    snap("lvl0");
    // Level 2 (20), level 9 saturating, level 5 at the floor (10).
    bus.level = 4'd2; run(100);
    bus.level = 4'd9; run(60);
    bus.level = 4'd5; run(60);

    // Shorten mid-count: count 30 at level 0, then level 3.
    bus.level = 4'd0; pulse_restart(); run(30);
    bus.level = 4'd3; run(40);

    // Pause 15 cycles at count 12.
    bus.level = 4'd0; pulse_restart(); run(12);
    bus.pause = 1'b1; run(15);
    snap("paused");
    bus.pause = 1'b0; run(70);

    // Restart with pause at count 25.
    pulse_restart(); run(25);
    bus.restart = 1'b1; bus.pause = 1'b1; run(1);
    bus.restart = 1'b0;
    snap("restart_pause");
    run(5);
    bus.pause = 1'b0; run(45);

    // Wrap tick_cnt at a 10-cycle period.
    bus.level = 4'd3; run(170);
    snap("wrap");

    // Reset mid-period with soft-drop held.
    bus.level = 4'd0; bus.fast = 1'b1; run(23);
    rst_n = 1'b0; run(1);
    snap("rst_fast");
    rst_n = 1'b1; run(40);
    bus.fast = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) bus.level = 4'($urandom_range(15));
      if ($urandom_range(59) == 0) bus.fast = ~bus.fast;
      if ($urandom_range(49) == 0) bus.pause = ~bus.pause;
      bus.restart = ($urandom_range(149) == 0);
      run(1);
    end

    bus.restart = 1'b0; bus.pause = 1'b0; bus.fast = 1'b0; bus.level = 4'd2;
    run(60);
    snap("final");
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
